// File: rtl/fadd_share_ctrl.sv
// Shares one pipelined float32 adder among N_REQ requesters: round-robin issue, ID tag delay line, credit-protected result FIFO.
// Define FADD_SHARE_PERF_EN to add the perf_issue/perf_stall counter ports.
module fadd_share_ctrl #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int ADD_LAT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_res,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id
`ifdef FADD_SHARE_PERF_EN
    ,
    output logic [31:0]           perf_issue,
    output logic [31:0]           perf_stall
`endif
);

    localparam int unsigned NR  = N_REQ;
    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam int          NST = ADD_LAT + 1;

    logic [ID_W-1:0] rr_ptr;
    logic [CW-1:0]   cnt;
    logic            allowed;
    logic            found;
    logic            issue;
    logic [ID_W-1:0] grant_id;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            push;
    logic            pop;

    logic [NST-1:0]  tag_vld;
    logic [ID_W-1:0] tag_id [NST];

    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0] fifo_id   [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fill;

    // Grant depends only on credit and requests, never on rsp_ready.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        found    = 1'b0;
        grant_id = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(rr_ptr) + k) % NR;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
        allowed   = (cnt < CW'(FIFO_DEPTH));
        issue     = allowed && found;
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
        sel_a = req_a[32*grant_id +: 32];
        sel_b = req_b[32*grant_id +: 32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a  <= '0;
            add_b  <= '0;
            rr_ptr <= '0;
        end else if (issue) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            rr_ptr <= (32'(grant_id) == NR - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k < NST; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[NST-2:0], issue};
            tag_id[0] <= grant_id;
            for (int unsigned k = 1; k < NST; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign push = tag_vld[NST-1];
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= add_res;
            fifo_id[wr_ptr]   <= tag_id[NST-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            case ({issue, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is gated while empty so the data/id outputs read zero after reset.
    assign rsp_valid = (fill != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]   : '0;

    assert property (@(posedge clk) disable iff (rst)
        !(push && (fill == (AW+1)'(FIFO_DEPTH))));

`ifdef FADD_SHARE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (issue)                  perf_issue <= perf_issue + 1'b1;
            if (|req_valid && !allowed) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Scoreboard bench for fadd_share_ctrl with a 3-stage float32 adder model; perf checks when FADD_SHARE_PERF_EN is defined.
module tb_fadd_share_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic [31:0]  add_res;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
`ifdef FADD_SHARE_PERF_EN
    logic [31:0]  perf_issue;
    logic [31:0]  perf_stall;
    logic [31:0]  p_iss0;
    logic [31:0]  p_st0;
`endif

    fadd_share_ctrl #(
        .N_REQ(4),
        .ID_W(2),
        .ADD_LAT(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .add_a(add_a),
        .add_b(add_b),
        .add_res(add_res),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id)
`ifdef FADD_SHARE_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [31:0] exp_sum [4];

    // Normal-number conversion only; operand vectors are exact in float32.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == '0) return 0.0;
        d = {f[31], 11'(32'(f[30:23]) + 896), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return '0;
        d = $realtobits(r);
        return {d[63], 8'(32'(d[62:52]) - 896), d[51:29]};
    endfunction

    logic [31:0] p0 = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    always @(posedge clk) begin
        p0 <= r2f(f2r(add_a) + f2r(add_b));
        p1 <= p0;
        p2 <= p1;
    end
    assign add_res = p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d data %h expected no response (cycle %0d)",
                         rsp_id, rsp_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                if (e.cyc >= 0) chk("rsp_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        exp_sum[i]        = s;
    endtask

    task automatic step(input logic [3:0] vmask, input logic rr, input logic [3:0] exp_rdy, input bit lat);
        exp_t e;
        @(negedge clk);
        req_valid = vmask;
        rsp_ready = rr;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.data = exp_sum[i];
                e.id   = 2'(i);
                e.cyc  = lat ? cyc + 5 : -1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(4'b0000, rr, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        set_op(1, 32'h40400000, 32'h3F800000, 32'h40800000);
        set_op(2, 32'h40000000, 32'h3F000000, 32'h40200000);
        set_op(3, 32'h3FC00000, 32'h3FC00000, 32'h40400000);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        rst = 1'b0;

        // single issue, latency 5
        step(4'b0001, 1'b1, 4'b0001, 1'b1);
        idle(8, 1'b1);

        // two simultaneous requests from reset
        do_reset();
        step(4'b0011, 1'b1, 4'b0001, 1'b1);
        step(4'b0010, 1'b1, 4'b0010, 1'b1);
        idle(8, 1'b1);

        // all four requesting; depth 4 throttles after four issues
        do_reset();
        step(4'b1111, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 1'b0);
        step(4'b1111, 1'b1, 4'b0100, 1'b0);
        step(4'b1111, 1'b1, 4'b1000, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 1'b0);
        step(4'b1111, 1'b1, 4'b0100, 1'b0);
        step(4'b1111, 1'b1, 4'b1000, 1'b0);
        idle(10, 1'b1);

        // credit exhaustion with rsp_ready low, then drain
`ifdef FADD_SHARE_PERF_EN
        p_iss0 = perf_issue;
        p_st0  = perf_stall;
`endif
        repeat (4) step(4'b0100, 1'b0, 4'b0100, 1'b0);
        repeat (2) step(4'b0100, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 1'b0);
`ifdef FADD_SHARE_PERF_EN
        chk("perf_issue_before_drain", perf_issue - p_iss0, 32'd4);
`endif
        step(4'b0100, 1'b1, 4'b0100, 1'b0);
`ifdef FADD_SHARE_PERF_EN
        chk("perf_stall", perf_stall - p_st0, 32'd3);
`endif
        idle(10, 1'b1);

        // async reset with two in flight and one buffered
        repeat (3) step(4'b0001, 1'b0, 4'b0001, 1'b0);
        idle(2, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_add_a", add_a, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(8, 1'b1);
        step(4'b0001, 1'b1, 4'b0001, 1'b1);
        idle(8, 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
